// File: rtl/riscv_tag_mem_ctrl_pkg.sv
// Shared types and default sizes for the tag memory controller slice.
package riscv_tag_mem_ctrl_pkg;

  localparam int TAG_W_DEFAULT    = 1;
  localparam int AW_DEFAULT       = 16;
  localparam int WB_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    TM_IDLE,
    TM_LD_REQ,
    TM_LD_WAIT,
    TM_ST_REQ
  } tag_mem_state_e;

endpackage

// File: rtl/riscv_tag_mem_ctrl_if.sv
// Single-port tag memory bus: req/gnt request phase, rvalid response phase.
interface riscv_tag_mem_ctrl_if
  import riscv_tag_mem_ctrl_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEFAULT,
  parameter int AW    = AW_DEFAULT
) ();

  logic             req;
  logic             we;
  logic [AW-1:0]    addr;
  logic [TAG_W-1:0] wdata;
  logic             gnt;
  logic             rvalid;
  logic [TAG_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/riscv_tag_wbuf.sv
// Circular store-tag write buffer with address lookup.
// TAG_STORE_FWD_EN adds a youngest-matching-entry data port.
module riscv_tag_wbuf #(
  parameter int TAG_W = 1,
  parameter int AW    = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [AW-1:0]    push_addr,
  input  logic [TAG_W-1:0] push_data,
  input  logic             pop,
  output logic [AW-1:0]    head_addr,
  output logic [TAG_W-1:0] head_data,
  output logic             full,
  output logic             empty,
  input  logic [AW-1:0]    lookup_addr,
  output logic [DEPTH-1:0] match_vec
`ifdef TAG_STORE_FWD_EN
  ,
  output logic [TAG_W-1:0] fwd_data
`endif
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      count;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [TAG_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end
  end

  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    valid     = '0;
    match_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i]     = ({1'b0, PW'(i) - rd_ptr} < count);
      match_vec[i] = valid[i] && (addr_q[i] == lookup_addr);
    end
  end

`ifdef TAG_STORE_FWD_EN
  // Walk oldest to youngest so the last hit is the youngest store.
  always_comb begin
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (((PW+1)'(k) < count) && (addr_q[rd_ptr + PW'(k)] == lookup_addr))
        fwd_data = data_q[rd_ptr + PW'(k)];
    end
  end
`endif

endmodule

// File: rtl/riscv_tag_mem_ctrl.sv
// Tag memory scheduler: posted store-tag writes, in-order load-tag reads with RAW protection.
// TAG_STORE_FWD_EN enables store-to-load tag forwarding from the write buffer.
module riscv_tag_mem_ctrl
  import riscv_tag_mem_ctrl_pkg::*;
#(
  parameter int TAG_W    = TAG_W_DEFAULT,
  parameter int AW       = AW_DEFAULT,
  parameter int WB_DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 st_req_i,
  input  logic [31:0]          st_addr_i,
  input  logic [TAG_W-1:0]     st_tag_i,
  input  logic                 st_en_i,
  output logic                 st_gnt_o,
  input  logic                 ld_req_i,
  input  logic [31:0]          ld_addr_i,
  output logic                 ld_gnt_o,
  output logic                 ld_rvalid_o,
  output logic [TAG_W-1:0]     ld_tag_o,
  riscv_tag_mem_ctrl_if.master tmem,
  output logic                 idle_o
);

  tag_mem_state_e state_q, state_d;

  logic [AW-1:0]       ld_word, st_word, ld_addr_q, head_addr;
  logic [TAG_W-1:0]    head_data;
  logic [WB_DEPTH-1:0] match_vec;
  logic                push, pop, full, empty, raw_hit;
  logic                unused_addr_bits;

  assign ld_word  = ld_addr_i[AW+1:2];
  assign st_word  = st_addr_i[AW+1:2];
  assign unused_addr_bits = ^{ld_addr_i[31:AW+2], ld_addr_i[1:0],
                              st_addr_i[31:AW+2], st_addr_i[1:0]};

  assign st_gnt_o = st_req_i & ~full;
  assign push     = st_gnt_o;
  assign pop      = (state_q == TM_ST_REQ) & tmem.gnt;
  assign raw_hit  = |match_vec;
  assign idle_o   = empty & (state_q == TM_IDLE);

`ifdef TAG_STORE_FWD_EN
  logic             fwd_fire, fwd_valid_q;
  logic [TAG_W-1:0] fwd_data, fwd_tag_q;
`endif

  riscv_tag_wbuf #(
    .TAG_W (TAG_W),
    .AW    (AW),
    .DEPTH (WB_DEPTH)
  ) u_wbuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_addr   (st_word),
    .push_data   (st_en_i ? st_tag_i : '0),
    .pop         (pop),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .full        (full),
    .empty       (empty),
    .lookup_addr (ld_word),
    .match_vec   (match_vec)
`ifdef TAG_STORE_FWD_EN
    ,
    .fwd_data    (fwd_data)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= TM_IDLE;
      ld_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == TM_IDLE && state_d == TM_LD_REQ) ld_addr_q <= ld_word;
    end
  end

  // The pushed entry is not yet in the buffer, so a same-cycle load only sees older stores.
  always_comb begin
    state_d    = state_q;
    ld_gnt_o   = 1'b0;
    tmem.req   = 1'b0;
    tmem.we    = 1'b0;
    tmem.addr  = '0;
    tmem.wdata = '0;
`ifdef TAG_STORE_FWD_EN
    fwd_fire   = 1'b0;
`endif
    case (state_q)
      TM_IDLE: begin
        if (full) begin
          state_d = TM_ST_REQ;
        end else if (ld_req_i && !raw_hit) begin
          ld_gnt_o = 1'b1;
          state_d  = TM_LD_REQ;
`ifdef TAG_STORE_FWD_EN
        end else if (ld_req_i) begin
          ld_gnt_o = 1'b1;
          fwd_fire = 1'b1;
`endif
        end else if (!empty) begin
          state_d = TM_ST_REQ;
        end
      end
      TM_LD_REQ: begin
        tmem.req  = 1'b1;
        tmem.addr = ld_addr_q;
        if (tmem.gnt) state_d = TM_LD_WAIT;
      end
      TM_LD_WAIT: begin
        if (tmem.rvalid) state_d = TM_IDLE;
      end
      TM_ST_REQ: begin
        tmem.req   = 1'b1;
        tmem.we    = 1'b1;
        tmem.addr  = head_addr;
        tmem.wdata = head_data;
        if (tmem.gnt) state_d = TM_IDLE;
      end
      default: state_d = TM_IDLE;
    endcase
  end

`ifdef TAG_STORE_FWD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_valid_q <= 1'b0;
      fwd_tag_q   <= '0;
    end else begin
      fwd_valid_q <= fwd_fire;
      fwd_tag_q   <= fwd_data;
    end
  end

  assign ld_rvalid_o = ((state_q == TM_LD_WAIT) & tmem.rvalid) | fwd_valid_q;
  assign ld_tag_o    = ((state_q == TM_LD_WAIT) & tmem.rvalid) ? tmem.rdata :
                       (fwd_valid_q ? fwd_tag_q : '0);
`else
  assign ld_rvalid_o = (state_q == TM_LD_WAIT) & tmem.rvalid;
  assign ld_tag_o    = ld_rvalid_o ? tmem.rdata : '0;
`endif

endmodule

// File: tb/tb_riscv_tag_mem_ctrl.sv
// Directed bench for riscv_tag_mem_ctrl: vector table plus multi-cycle corner sequences.
module tb_riscv_tag_mem_ctrl;

  localparam int W_ST = 0, W_LD = 1, W_RV = 2, W_IDLE = 3;

  typedef struct {
    bit          is_load;
    logic [31:0] addr;
    logic [0:0]  tag;
    logic        en;
    logic [0:0]  rdata;
    logic [15:0] exp_addr;
    logic [0:0]  exp_data;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [0:0]  data;
    logic [15:0] addr;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_req, st_en, ld_req;
  logic [31:0] st_addr, ld_addr;
  logic [0:0]  st_tag;
  logic        st_gnt, ld_gnt, ld_rvalid, idle;
  logic [0:0]  ld_tag;
  logic        gnt_en;
  logic [0:0]  mem_rdata;
  int          rd_lat;
  int          rv_cnt  = 0;
  int          rv_seen = 0;
  int          tests   = 0;
  int          fails   = 0;
  txn_t        log[$];
  vec_t        vecs[7];

  always #5 clk = ~clk;

  riscv_tag_mem_ctrl_if #(.TAG_W(1), .AW(16)) tmem ();

  riscv_tag_mem_ctrl #(.TAG_W(1), .AW(16), .WB_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .st_req_i    (st_req),
    .st_addr_i   (st_addr),
    .st_tag_i    (st_tag),
    .st_en_i     (st_en),
    .st_gnt_o    (st_gnt),
    .ld_req_i    (ld_req),
    .ld_addr_i   (ld_addr),
    .ld_gnt_o    (ld_gnt),
    .ld_rvalid_o (ld_rvalid),
    .ld_tag_o    (ld_tag),
    .tmem        (tmem),
    .idle_o      (idle)
  );

  // Memory model: grants when enabled, answers reads rd_lat cycles after grant, ignores rst_n.
  assign tmem.gnt    = tmem.req & gnt_en;
  assign tmem.rvalid = (rv_cnt == 1);
  assign tmem.rdata  = mem_rdata;

  always @(posedge clk) begin
    if (tmem.req && tmem.gnt && !tmem.we) rv_cnt <= rd_lat;
    else if (rv_cnt > 0)                  rv_cnt <= rv_cnt - 1;
    if (tmem.req && tmem.gnt) log.push_back({tmem.we, tmem.wdata, tmem.addr});
    if (ld_rvalid) rv_seen <= rv_seen + 1;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] txnAt(input int idx);
    if (idx < log.size()) return 32'(log[idx]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] txnPack(input logic we, input logic [0:0] data, input logic [15:0] addr);
    return {14'd0, we, data, addr};
  endfunction

  function automatic logic sigSel(input int which);
    case (which)
      W_ST:    return st_gnt;
      W_LD:    return ld_gnt;
      W_RV:    return ld_rvalid;
      default: return idle;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitFor(input int which, input int budget, input string name, output logic [0:0] tag_at);
    logic hit;
    hit    = 1'b0;
    tag_at = '0;
    for (int n = 0; n < budget && !hit; n++) begin
      @(negedge clk);
      if (sigSel(which)) begin
        hit    = 1'b1;
        tag_at = ld_tag;
      end
    end
    checkOutput({name, "_reached"}, 32'(hit), 32'd1);
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    int         base;
    logic [0:0] t;
    base = log.size();
    if (!v.is_load) begin
      st_req = 1'b1; st_addr = v.addr; st_tag = v.tag; st_en = v.en;
      waitFor(W_ST, 10, {name, "_stgnt"}, t);
      tick();
      st_req = 1'b0;
      waitFor(W_IDLE, 20, {name, "_idle"}, t);
      checkOutput({name, "_ntxn"}, 32'(log.size() - base), 32'd1);
      checkOutput({name, "_wr"}, txnAt(base), txnPack(1'b1, v.exp_data, v.exp_addr));
    end else begin
      mem_rdata = v.rdata;
      ld_req = 1'b1; ld_addr = v.addr;
      waitFor(W_LD, 10, {name, "_ldgnt"}, t);
      tick();
      ld_req = 1'b0;
      waitFor(W_RV, 20, {name, "_rvalid"}, t);
      checkOutput({name, "_tag"}, 32'(t), 32'(v.exp_data));
      waitFor(W_IDLE, 20, {name, "_idle"}, t);
      checkOutput({name, "_rd"}, txnAt(base), txnPack(1'b0, 1'b0, v.exp_addr));
    end
  endtask

  initial begin
    int         base;
    int         rv_before;
    logic [0:0] t;

    vecs[0] = '{is_load:0, addr:32'h0000_0200, tag:1, en:0, rdata:0, exp_addr:16'h0080, exp_data:0};
    vecs[1] = '{is_load:0, addr:32'h0000_0204, tag:1, en:1, rdata:0, exp_addr:16'h0081, exp_data:1};
    vecs[2] = '{is_load:0, addr:32'h0000_0208, tag:0, en:1, rdata:0, exp_addr:16'h0082, exp_data:0};
    vecs[3] = '{is_load:0, addr:32'h0004_020F, tag:1, en:1, rdata:0, exp_addr:16'h0083, exp_data:1};
    vecs[4] = '{is_load:1, addr:32'h0000_0300, tag:0, en:0, rdata:1, exp_addr:16'h00C0, exp_data:1};
    vecs[5] = '{is_load:1, addr:32'h0000_0304, tag:0, en:0, rdata:0, exp_addr:16'h00C1, exp_data:0};
    vecs[6] = '{is_load:1, addr:32'h0003_FFFC, tag:0, en:0, rdata:1, exp_addr:16'hFFFF, exp_data:1};

    rst_n = 1'b0; st_req = 1'b0; st_addr = '0; st_tag = '0; st_en = 1'b0;
    ld_req = 1'b0; ld_addr = '0; gnt_en = 1'b0; rd_lat = 2; mem_rdata = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_idle",   32'(idle), 32'd1);
    checkOutput("rst_stgnt",  32'(st_gnt), 32'd0);
    checkOutput("rst_ldgnt",  32'(ld_gnt), 32'd0);
    checkOutput("rst_rvalid", 32'(ld_rvalid), 32'd0);
    checkOutput("rst_tag",    32'(ld_tag), 32'd0);
    checkOutput("rst_tmem",   32'({tmem.req, tmem.we, tmem.wdata, tmem.addr}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Fill the buffer with the memory stalled, then release it
    base = log.size();
    for (int i = 0; i < 4; i++) begin
      st_req = 1'b1; st_addr = 32'h100 + 32'(4 * i); st_tag = 1'b1; st_en = 1'b1;
      @(negedge clk);
      checkOutput($sformatf("t1_stgnt%0d", i), 32'(st_gnt), 32'd1);
      tick();
    end
    st_addr = 32'h110;
    @(negedge clk);
    checkOutput("t1_full_refused", 32'(st_gnt), 32'd0);
    checkOutput("t1_req_stable", 32'({tmem.req, tmem.we, tmem.addr}), 32'h0003_0040);
    tick();
    @(negedge clk);
    checkOutput("t1_full_refused2", 32'(st_gnt), 32'd0);
    checkOutput("t1_no_grant_yet", 32'(log.size() - base), 32'd0);
    tick();
    st_req = 1'b0;
    gnt_en = 1'b1;
    waitFor(W_IDLE, 30, "t1_drain", t);
    checkOutput("t1_ntxn", 32'(log.size() - base), 32'd4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("t1_wr%0d", i), txnAt(base + i), txnPack(1'b1, 1'b1, 16'h0040 + 16'(i)));
    tick();

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
      tick();
    end

    // Load timing on an empty buffer, rvalid two cycles after grant
    mem_rdata = 1'b1;
    ld_req = 1'b1; ld_addr = 32'h300;
    @(negedge clk);
    checkOutput("t3_ldgnt_idle", 32'({ld_gnt, tmem.req}), 32'h2);
    tick();
    ld_req = 1'b0;
    @(negedge clk);
    checkOutput("t3_rdreq", 32'({tmem.req, tmem.we, tmem.addr}), 32'h0002_00C0);
    tick();
    @(negedge clk);
    checkOutput("t3_no_rvalid_yet", 32'(ld_rvalid), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("t3_rvalid_tag", 32'({ld_rvalid, ld_tag}), 32'h3);
    tick();
    @(negedge clk);
    checkOutput("t3_done", 32'({ld_rvalid, idle}), 32'h1);
    tick();

    // RAW hit on a buffered store
    base = log.size();
    st_req = 1'b1; st_addr = 32'h400; st_tag = 1'b1; st_en = 1'b1;
    @(negedge clk);
    checkOutput("t4_stgnt", 32'(st_gnt), 32'd1);
    tick();
    st_req = 1'b0;
    ld_req = 1'b1; ld_addr = 32'h400;
`ifdef TAG_STORE_FWD_EN
    mem_rdata = 1'b0;
    @(negedge clk);
    checkOutput("t4_fwd_ldgnt", 32'({ld_gnt, tmem.req}), 32'h2);
    tick();
    ld_req = 1'b0;
    @(negedge clk);
    checkOutput("t4_fwd_rvalid_tag", 32'({ld_rvalid, ld_tag}), 32'h3);
    waitFor(W_IDLE, 20, "t4_idle", t);
    checkOutput("t4_ntxn", 32'(log.size() - base), 32'd1);
    checkOutput("t4_wr", txnAt(base), txnPack(1'b1, 1'b1, 16'h0100));
`else
    mem_rdata = 1'b1;
    waitFor(W_LD, 20, "t4_ldgnt", t);
    checkOutput("t4_write_first", 32'(log.size() - base), 32'd1);
    tick();
    ld_req = 1'b0;
    waitFor(W_RV, 20, "t4_rvalid", t);
    checkOutput("t4_tag", 32'(t), 32'd1);
    waitFor(W_IDLE, 20, "t4_idle", t);
    checkOutput("t4_wr", txnAt(base), txnPack(1'b1, 1'b1, 16'h0100));
    checkOutput("t4_rd", txnAt(base + 1), txnPack(1'b0, 1'b0, 16'h0100));
`endif
    tick();

    // Buffer fills during a slow read; a pending load waits for exactly one drain
    base = log.size();
    rd_lat = 8; mem_rdata = 1'b0;
    ld_req = 1'b1; ld_addr = 32'h700;
    waitFor(W_LD, 10, "t5_ldgnt_a", t);
    tick();
    ld_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      st_req = 1'b1; st_addr = 32'h600 + 32'(4 * i); st_tag = 1'b1; st_en = 1'b1;
      @(negedge clk);
      checkOutput($sformatf("t5_stgnt%0d", i), 32'(st_gnt), 32'd1);
      tick();
    end
    st_req = 1'b0;
    ld_req = 1'b1; ld_addr = 32'h500;
    @(negedge clk);
    checkOutput("t5_ld_blocked", 32'(ld_gnt), 32'd0);
    waitFor(W_LD, 40, "t5_ldgnt_b", t);
    tick();
    ld_req = 1'b0;
    waitFor(W_RV, 20, "t5_rvalid_b", t);
    waitFor(W_IDLE, 40, "t5_idle", t);
    checkOutput("t5_ntxn", 32'(log.size() - base), 32'd6);
    checkOutput("t5_rd_a", txnAt(base),     txnPack(1'b0, 1'b0, 16'h01C0));
    checkOutput("t5_wr0",  txnAt(base + 1), txnPack(1'b1, 1'b1, 16'h0180));
    checkOutput("t5_rd_b", txnAt(base + 2), txnPack(1'b0, 1'b0, 16'h0140));
    for (int i = 1; i < 4; i++)
      checkOutput($sformatf("t5_wr%0d", i), txnAt(base + 2 + i), txnPack(1'b1, 1'b1, 16'h0180 + 16'(i)));
    rd_lat = 2;
    tick();

    // Reset during LD_WAIT with two buffered stores
    rd_lat = 6; mem_rdata = 1'b1;
    ld_req = 1'b1; ld_addr = 32'h800;
    waitFor(W_LD, 10, "t6_ldgnt", t);
    tick();
    ld_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      st_req = 1'b1; st_addr = 32'h900 + 32'(4 * i); st_tag = 1'b1; st_en = 1'b1;
      @(negedge clk);
      checkOutput($sformatf("t6_stgnt%0d", i), 32'(st_gnt), 32'd1);
      tick();
    end
    st_req = 1'b0;
    rst_n  = 1'b0;
    rv_before = rv_seen;
    base = log.size();
    @(negedge clk);
    checkOutput("t6_rst_idle", 32'({idle, tmem.req, ld_rvalid}), 32'h4);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    checkOutput("t6_no_stale_rvalid", 32'(rv_seen - rv_before), 32'd0);
    checkOutput("t6_buffer_dropped", 32'(log.size() - base), 32'd0);
    checkOutput("t6_idle_after", 32'({idle, tmem.req}), 32'h2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
